// File: rtl/rob_ring_mp.sv
// rob_ring_mp: multi-port reorder-buffer ring with in-order allocate,
// out-of-order writeback, up to COMMIT_W in-order retirements per cycle,
// and partial squash of every entry younger than a surviving tag.
module rob_ring_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned WB_PORTS = 8,
    parameter int unsigned COMMIT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [DATA_W-1:0]            issue_data,
    output logic                         issue_ready,
    output logic [IDX_W-1:0]             issue_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*IDX_W-1:0]    commit_tag,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    input  logic [COMMIT_W-1:0]          commit_pop,
    input  logic                         flush_valid,
    input  logic [IDX_W-1:0]             flush_tag,
    output logic [IDX_W:0]               count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned    DEPTH     = 1 << IDX_W;
    localparam logic [IDX_W:0] DEPTH_CNT = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] ONE       = (IDX_W + 1)'(1);

    logic [IDX_W:0]    head, tail, occ;
    logic [IDX_W:0]    head_next, tail_next, pop_n, flush_tail;
    logic [IDX_W-1:0]  head_idx, tail_idx, flush_dist;
    logic [DEPTH-1:0]  valid, done, kill;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [COMMIT_W:0] ready_chain, pop_chain;
    logic              issue_acc, flush_all_popped;

    assign occ         = tail - head;
    assign count       = occ;
    assign full        = (occ == DEPTH_CNT);
    assign empty       = (occ == '0);
    assign issue_ready = ~full;
    assign head_idx    = head[IDX_W-1:0];
    assign tail_idx    = tail[IDX_W-1:0];
    assign issue_tag   = tail_idx;
    assign issue_acc   = issue_valid & ~full & ~flush_valid;

    // Retire window: lane i is ready only if every older lane is ready, and a
    // pop is honoured only along the unbroken prefix of popped ready lanes.
    assign ready_chain[0] = 1'b1;
    assign pop_chain[0]   = 1'b1;
    for (genvar i = 0; i < COMMIT_W; i++) begin : g_commit
        logic [IDX_W-1:0] idx;
        assign idx              = head_idx + IDX_W'(i);
        assign ready_chain[i+1] = ready_chain[i] & valid[idx] & done[idx];
        assign pop_chain[i+1]   = pop_chain[i] & commit_pop[i] & ready_chain[i+1];
        assign commit_tag[i*IDX_W +: IDX_W]    = idx;
        assign commit_data[i*DATA_W +: DATA_W] = mem[idx];
    end
    assign commit_valid = ready_chain[COMMIT_W:1];

    // Number of entries retired this cycle.
    always_comb begin
        pop_n = '0;
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            pop_n = pop_n + (IDX_W + 1)'(pop_chain[i+1]);
        end
    end

    // Flush keeps everything up to flush_tag; the tail is rebuilt from head so
    // the wrap bit stays consistent. If the surviving youngest entry is itself
    // retired this cycle, head must land on the same point to leave an empty ring.
    assign flush_dist       = flush_tag - head_idx;
    assign flush_tail       = head + {1'b0, flush_dist} + ONE;
    assign flush_all_popped = ({1'b0, flush_dist} < pop_n);
    assign head_next        = (flush_valid & flush_all_popped) ? flush_tail : head + pop_n;
    assign tail_next        = flush_valid ? flush_tail : tail + (IDX_W + 1)'(issue_acc);

    // Entries cleared this cycle: retired ones plus those younger than flush_tag.
    for (genvar j = 0; j < DEPTH; j++) begin : g_kill
        logic [IDX_W-1:0] off;
        assign off     = IDX_W'(j) - head_idx;
        assign kill[j] = ({1'b0, off} < pop_n)
                       | (flush_valid & (off > flush_dist) & ({1'b0, off} < occ));
    end

    // Pointer and per-entry status update; later assignments take priority
    // (issue over writeback, squash/retire over everything).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            head <= head_next;
            tail <= tail_next;
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && valid[wb_tag[p*IDX_W +: IDX_W]]) begin
                    done[wb_tag[p*IDX_W +: IDX_W]] <= 1'b1;
                end
            end
            if (issue_acc) begin
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= 1'b0;
            end
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (kill[j]) begin
                    valid[j] <= 1'b0;
                    done[j]  <= 1'b0;
                end
            end
        end
    end

    // Payload storage; highest-numbered writeback port wins on a shared tag.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && valid[wb_tag[p*IDX_W +: IDX_W]]) begin
                mem[wb_tag[p*IDX_W +: IDX_W]] <= wb_data[p*DATA_W +: DATA_W];
            end
        end
        if (issue_acc) begin
            mem[tail_idx] <= issue_data;
        end
    end

endmodule

// File: tb/tb_rob_ring_mp.sv
// tb_rob_ring_mp: directed scenarios plus randomized traffic checked against
// a program-order queue model of the reorder buffer.
module tb_rob_ring_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue_valid;
    logic [31:0]  issue_data;
    logic         issue_ready;
    logic [4:0]   issue_tag;
    logic [7:0]   wb_valid;
    logic [39:0]  wb_tag;
    logic [255:0] wb_data;
    logic [1:0]   commit_valid;
    logic [9:0]   commit_tag;
    logic [63:0]  commit_data;
    logic [1:0]   commit_pop;
    logic         flush_valid;
    logic [4:0]   flush_tag;
    logic [5:0]   count;
    logic         full;
    logic         empty;

    int vectors = 0;
    int errors  = 0;

    // Model: live entries oldest-first; mhead is the head pointer modulo 64.
    typedef struct {
        bit          done;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    int   mhead;

    rob_ring_mp #(.DATA_W(32), .IDX_W(5), .WB_PORTS(8), .COMMIT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_data(issue_data),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_data(commit_data),
        .commit_pop(commit_pop), .flush_valid(flush_valid), .flush_tag(flush_tag),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic idle();
        issue_valid = 1'b0;
        issue_data  = '0;
        wb_valid    = '0;
        wb_tag      = '0;
        wb_data     = '0;
        commit_pop  = '0;
        flush_valid = 1'b0;
        flush_tag   = '0;
    endtask

    function automatic bit m_cv(input int i);
        if (i >= mq.size()) return 1'b0;
        for (int j = 0; j <= i; j++) if (!mq[j].done) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update(input int n);
        int   old, sz, pos, k, pc;
        ent_t e;
        old = mhead % 32;
        sz  = mq.size();
        for (int p = 0; p < 8; p++) begin
            if (wb_valid[p]) begin
                pos = (int'(wb_tag[p*5 +: 5]) - old + 32) % 32;
                if (pos < sz) begin
                    e = mq[pos];
                    e.done = 1'b1;
                    e.data = wb_data[p*32 +: 32];
                    mq[pos] = e;
                end
            end
        end
        if (flush_valid) begin
            k = (int'(flush_tag) - old + 32) % 32;
            while (mq.size() > k + 1) void'(mq.pop_back());
        end else if (issue_valid && sz < 32) begin
            e.done = 1'b0;
            e.data = issue_data;
            mq.push_back(e);
        end
        pc = (n < mq.size()) ? n : mq.size();
        for (int i = 0; i < pc; i++) void'(mq.pop_front());
        mhead = (mhead + pc) % 64;
    endtask

    // One clock: the model takes the same inputs the DUT sees at the edge.
    task automatic tick();
        int n;
        n = 0;
        for (int i = 0; i < 2; i++) if (n == i && commit_pop[i] && m_cv(i)) n++;
        @(posedge clk);
        m_update(n);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mhead = 0;
    endtask

    task automatic issue_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            issue_valid = 1'b1;
            issue_data  = 32'(base + i);
            tick();
        end
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if ({full, empty, issue_ready} !== 3'b011) begin errors++; $display("FAIL reset_flags: got full/empty/ready=%b expected 011", {full, empty, issue_ready}); end
        vectors++; if (issue_tag !== 5'd0) begin errors++; $display("FAIL reset_issue_tag: got %0d expected 0", issue_tag); end
        vectors++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit_valid: got %b expected 00", commit_valid); end
        rst = 1'b0;
        mq.delete();
        mhead = 0;
        tick();
        vectors++; if ({count, empty, commit_valid} !== {6'd0, 1'b1, 2'b00}) begin errors++; $display("FAIL reset_release: got count=%0d empty=%b cv=%b expected 0/1/00", count, empty, commit_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            vectors++; if (issue_tag !== 5'(i)) begin errors++; $display("FAIL fill_issue_tag: got %0d expected %0d", issue_tag, i); end
            issue_valid = 1'b1;
            issue_data  = 32'(i);
            tick();
        end
        issue_valid = 1'b0;
        vectors++; if ({full, issue_ready} !== 2'b10) begin errors++; $display("FAIL fill_full: got full/ready=%b expected 10", {full, issue_ready}); end
        vectors++; if (count !== 6'd32) begin errors++; $display("FAIL fill_count: got %0d expected 32", count); end
        issue_valid = 1'b1;
        issue_data  = 32'hBAD0_BAD0;
        tick();
        issue_valid = 1'b0;
        vectors++; if (count !== 6'd32) begin errors++; $display("FAIL fill_overflow_count: got %0d expected 32", count); end
        vectors++; if (issue_tag !== 5'd0) begin errors++; $display("FAIL fill_overflow_tag: got %0d expected 0", issue_tag); end
        vectors++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL fill_commit_valid: got %b expected 00", commit_valid); end
    endtask

    task automatic test_out_of_order();
        int order[4];
        order[0] = 3; order[1] = 1; order[2] = 2; order[3] = 0;
        do_reset();
        issue_n(4, 100);
        for (int k = 0; k < 4; k++) begin
            wb_valid       = 8'h01;
            wb_tag[4:0]    = 5'(order[k]);
            wb_data[31:0]  = 32'h1000 + 32'(order[k]);
            tick();
            idle();
            if (k < 3) begin
                vectors++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait_%0d: got %b expected 00", k, commit_valid); end
            end else begin
                vectors++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL ooo_ready: got %b expected 11", commit_valid); end
            end
        end
        vectors++; if (commit_tag !== {5'd1, 5'd0}) begin errors++; $display("FAIL ooo_tags01: got %h expected %h", commit_tag, {5'd1, 5'd0}); end
        vectors++; if (commit_data !== {32'h1001, 32'h1000}) begin errors++; $display("FAIL ooo_data01: got %h expected %h", commit_data, {32'h1001, 32'h1000}); end
        commit_pop = 2'b11;
        tick();
        commit_pop = 2'b00;
        vectors++; if (commit_tag !== {5'd3, 5'd2}) begin errors++; $display("FAIL ooo_tags23: got %h expected %h", commit_tag, {5'd3, 5'd2}); end
        vectors++; if ({commit_valid, count} !== {2'b11, 6'd2}) begin errors++; $display("FAIL ooo_after_pop: got cv=%b count=%0d expected 11/2", commit_valid, count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            vectors++; if (issue_tag !== 5'(i % 32)) begin errors++; $display("FAIL wrap_issue_tag: got %0d expected %0d", issue_tag, i % 32); end
            issue_valid = 1'b1;
            issue_data  = $urandom;
            tick();
            issue_valid = 1'b0;
            vectors++; if ({count, full, empty} !== {6'd1, 2'b00}) begin errors++; $display("FAIL wrap_one: got count=%0d full=%b empty=%b expected 1/0/0", count, full, empty); end
            wb_valid      = 8'h01;
            wb_tag[4:0]   = 5'(i % 32);
            wb_data[31:0] = 32'h2000 + 32'(i);
            tick();
            idle();
            vectors++; if ({commit_valid, commit_data[31:0]} !== {2'b01, 32'h2000 + 32'(i)}) begin errors++; $display("FAIL wrap_commit: got cv=%b data=%h expected 01/%h", commit_valid, commit_data[31:0], 32'h2000 + 32'(i)); end
            commit_pop = 2'b01;
            tick();
            commit_pop = 2'b00;
            vectors++; if ({count, full, empty} !== {6'd0, 2'b01}) begin errors++; $display("FAIL wrap_empty: got count=%0d full=%b empty=%b expected 0/0/1", count, full, empty); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue_n(28, 0);
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 8; p++) begin
                if (c * 8 + p < 28) begin
                    wb_valid[p]        = 1'b1;
                    wb_tag[p*5 +: 5]   = 5'(c * 8 + p);
                    wb_data[p*32 +: 32] = 32'(c * 8 + p);
                end
            end
            tick();
            idle();
        end
        for (int c = 0; c < 14; c++) begin
            commit_pop = 2'b11;
            tick();
        end
        commit_pop = 2'b00;
        vectors++; if ({empty, issue_tag} !== {1'b1, 5'd28}) begin errors++; $display("FAIL flush_setup: got empty=%b tag=%0d expected 1/28", empty, issue_tag); end
        issue_n(10, 300);
        vectors++; if (count !== 6'd10) begin errors++; $display("FAIL flush_count10: got %0d expected 10", count); end
        flush_valid   = 1'b1;
        flush_tag     = 5'd30;
        wb_valid      = 8'h01;
        wb_tag[4:0]   = 5'd2;
        wb_data[31:0] = 32'hDEAD;
        tick();
        idle();
        vectors++; if (count !== 6'd3) begin errors++; $display("FAIL flush_count: got %0d expected 3", count); end
        vectors++; if (issue_tag !== 5'd31) begin errors++; $display("FAIL flush_issue_tag: got %0d expected 31", issue_tag); end
        issue_n(4, 400);
        for (int p = 0; p < 6; p++) begin
            wb_valid[p]         = 1'b1;
            wb_tag[p*5 +: 5]    = 5'((28 + p) % 32);
            wb_data[p*32 +: 32] = 32'h4000 + 32'(p);
        end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            commit_pop = 2'b11;
            tick();
        end
        commit_pop = 2'b00;
        vectors++; if ({commit_tag[4:0], commit_valid, count} !== {5'd2, 2'b00, 6'd1}) begin errors++; $display("FAIL flush_wb_dropped: got tag=%0d cv=%b count=%0d expected 2/00/1", commit_tag[4:0], commit_valid, count); end
    endtask

    task automatic test_conflict();
        int tg[8];
        tg[0] = 0; tg[1] = 1; tg[2] = 7; tg[3] = 2; tg[4] = 3; tg[5] = 7; tg[6] = 4; tg[7] = 5;
        do_reset();
        issue_n(8, 500);
        for (int p = 0; p < 8; p++) begin
            wb_valid[p]         = 1'b1;
            wb_tag[p*5 +: 5]    = 5'(tg[p]);
            wb_data[p*32 +: 32] = 32'h6000 + 32'(tg[p]);
        end
        wb_data[2*32 +: 32] = 32'hAAAA;
        wb_data[5*32 +: 32] = 32'h5555;
        tick();
        idle();
        wb_valid      = 8'h01;
        wb_tag[4:0]   = 5'd6;
        wb_data[31:0] = 32'h6006;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            commit_pop = 2'b11;
            tick();
        end
        commit_pop = 2'b00;
        vectors++; if ({commit_valid, commit_tag} !== {2'b11, 5'd7, 5'd6}) begin errors++; $display("FAIL conflict_head: got cv=%b tags=%h expected 11/%h", commit_valid, commit_tag, {5'd7, 5'd6}); end
        vectors++; if (commit_data[63:32] !== 32'h5555) begin errors++; $display("FAIL conflict_data: got %h expected 00005555", commit_data[63:32]); end
        flush_valid = 1'b1;
        flush_tag   = 5'd7;
        issue_valid = 1'b1;
        issue_data  = 32'hFEED;
        tick();
        idle();
        vectors++; if ({count, issue_tag} !== {6'd2, 5'd8}) begin errors++; $display("FAIL conflict_flush_issue: got count=%0d tag=%0d expected 2/8", count, issue_tag); end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_n(12, 700);
        vectors++; if (count !== 6'd12) begin errors++; $display("FAIL async_setup: got %0d expected 12", count); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({count, empty} !== {6'd0, 1'b1}) begin errors++; $display("FAIL async_clear: got count=%0d empty=%b expected 0/1", count, empty); end
        vectors++; if ({issue_tag, commit_valid} !== {5'd0, 2'b00}) begin errors++; $display("FAIL async_outputs: got tag=%0d cv=%b expected 0/00", issue_tag, commit_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mhead = 0;
        tick();
        vectors++; if ({count, empty, issue_ready} !== {6'd0, 2'b11}) begin errors++; $display("FAIL async_after: got count=%0d empty=%b ready=%b expected 0/1/1", count, empty, issue_ready); end
    endtask

    task automatic test_random();
        int sz;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sz = mq.size();
            vectors++; if (count !== 6'(sz)) begin errors++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, count, sz); end
            vectors++; if ({full, empty, issue_ready} !== {sz == 32, sz == 0, sz != 32}) begin errors++; $display("FAIL rand_flags cyc %0d: got %b expected %b", cyc, {full, empty, issue_ready}, {sz == 32, sz == 0, sz != 32}); end
            vectors++; if (issue_tag !== 5'((mhead + sz) % 32)) begin errors++; $display("FAIL rand_issue_tag cyc %0d: got %0d expected %0d", cyc, issue_tag, (mhead + sz) % 32); end
            vectors++; if (commit_valid !== {m_cv(1), m_cv(0)}) begin errors++; $display("FAIL rand_commit_valid cyc %0d: got %b expected %b", cyc, commit_valid, {m_cv(1), m_cv(0)}); end
            for (int i = 0; i < 2; i++) begin
                vectors++; if (commit_tag[i*5 +: 5] !== 5'((mhead + i) % 32)) begin errors++; $display("FAIL rand_commit_tag%0d cyc %0d: got %0d expected %0d", i, cyc, commit_tag[i*5 +: 5], (mhead + i) % 32); end
                if (m_cv(i)) begin
                    vectors++; if (commit_data[i*32 +: 32] !== mq[i].data) begin errors++; $display("FAIL rand_commit_data%0d cyc %0d: got %h expected %h", i, cyc, commit_data[i*32 +: 32], mq[i].data); end
                end
            end
            idle();
            issue_valid = ($urandom_range(9, 0) < 7);
            issue_data  = $urandom;
            for (int p = 0; p < 8; p++) begin
                wb_valid[p] = ($urandom_range(3, 0) == 0);
                if (sz > 0 && $urandom_range(3, 0) != 0)
                    wb_tag[p*5 +: 5] = 5'((mhead + $urandom_range(sz - 1, 0)) % 32);
                else
                    wb_tag[p*5 +: 5] = 5'($urandom_range(31, 0));
                wb_data[p*32 +: 32] = $urandom;
            end
            commit_pop = 2'($urandom_range(3, 0));
            if (sz > 0 && $urandom_range(24, 0) == 0) begin
                flush_valid = 1'b1;
                flush_tag   = 5'((mhead + $urandom_range(sz - 1, 0)) % 32);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst   = 1'b1;
        mhead = 0;
        test_reset();
        test_fill();
        test_out_of_order();
        test_wrap();
        test_flush();
        test_conflict();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rob_ring_mp.md
# rob_ring_mp

Parametrised multi-port reorder-buffer ring, the next generation of the ROB circular queue. It allocates entries in program order, accepts out-of-order writebacks from a configurable number of broadcast ports, and retires up to COMMIT_W completed entries per cycle from the head. It also supports partial squash on branch mispredict, flushing every entry younger than a given tag. It sits between dispatch (issue side), the functional-unit CDB ports (writeback side) and the register-file/store commit logic.

## Interface
- DATA_W, 32, width of an entry payload
- IDX_W, 5, log2 of depth; depth = 2**IDX_W; tag width
- WB_PORTS, 8, number of writeback broadcast ports
- COMMIT_W, 2, maximum retirements per cycle (1..4)

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous, active-high
- issue_valid  in  1  allocate one entry at the tail
- issue_data  in  DATA_W  initial payload for the allocated entry
- issue_ready  out  1  ring not full
- issue_tag  out  IDX_W  index the next issue will receive (tail index)
- wb_valid  in  WB_PORTS  per-port writeback strobe
- wb_tag  in  WB_PORTS*IDX_W  per-port target index; port p uses bits [p*IDX_W +: IDX_W]
- wb_data  in  WB_PORTS*DATA_W  per-port result payload
- commit_valid  out  COMMIT_W  bit i: entry head+i is retireable
- commit_tag  out  COMMIT_W*IDX_W  index of entry head+i
- commit_data  out  COMMIT_W*DATA_W  payload of entry head+i
- commit_pop  in  COMMIT_W  retire request; must be a prefix of commit_valid
- flush_valid  in  1  squash all entries younger than flush_tag
- flush_tag  in  IDX_W  surviving youngest entry; must be a valid entry
- count  out  IDX_W+1  occupied entries, 0..2**IDX_W
- full  out  1  count == 2**IDX_W
- empty  out  1  count == 0

## Operation
- State:
  - head and tail pointers, IDX_W+1 bits each; the MSB is the wrap bit.
  - Per entry: valid, done, data.
  - count = tail - head, modulo 2**(IDX_W+1).
- Issue:
  - When issue_valid & issue_ready & ~flush_valid, the entry at tail[IDX_W-1:0] gets valid=1, done=0, data=issue_data.
  - tail increments by 1.
  - issue_valid while full is ignored; no state change.
- Writeback:
  - For each port with wb_valid, if the target entry is valid, set done=1 and data=wb_data.
  - Writeback to an invalid entry is dropped.
  - Same tag on several ports in the same cycle: the highest-numbered port wins.
- Commit:
  - commit_valid[i] = entry(head+i).valid & entry(head+i).done & commit_valid[i-1]. The chain starts at i=0 with no predecessor term.
  - commit_tag and commit_data are driven combinationally from registered state.
  - Let n = number of asserted commit_pop bits. The n head entries get valid=0, done=0, and head advances by n.
  - Pop bits that are not a prefix of commit_valid: only the prefix that is both popped and valid is honoured.
- Flush:
  - The new tail is head + ((flush_tag - head[IDX_W-1:0]) mod 2**IDX_W) + 1, with the wrap bit computed consistently.
  - All entries strictly between flush_tag and the old tail get valid=0, done=0.
  - flush_tag itself is retained.
- Simultaneous events:
  - Flush beats issue; the issue is dropped.
  - Flush beats writeback to any squashed entry.
  - Issue beats writeback at the same index.
  - Commit and flush in the same cycle both apply. If flush_tag is among the popped entries, the ring ends empty with head = tail = flush_tag+1.
  - Commit and issue in the same cycle: count changes by 1 - n.
- Wrap-around: index arithmetic is modulo 2**IDX_W. Full versus empty is distinguished only by the wrap bit.

## Timing
- Reset (asynchronous):
  - head = tail = 0; all valid and done bits = 0; data unspecified.
  - Outputs while rst is high and immediately after release: count=0, empty=1, full=0, issue_ready=1, issue_tag=0, commit_valid=0.
- Reset asserted mid-operation clears the ring immediately, without waiting for a clock edge.
- issue_ready, full and empty derive from registered count only. A commit in cycle N does not free a slot for an issue in cycle N.
- Latency:
  - Issue in cycle N: the entry is valid from N+1.
  - Writeback in cycle M: done from M+1, and commit_valid can assert in M+1.
  - Minimum issue-to-commit latency is 2 cycles.
- Flush takes effect at the next edge. issue_tag in the following cycle equals flush_tag+1.
- No output depends combinationally on issue_valid, wb_* or flush_*. commit outputs depend only on registered state.

## Test plan
- Reset then fill: 32 issues with data 0..31 -> issue_tag runs 0..31; full=1, issue_ready=0, count=32. A 33rd issue is ignored.
- Out-of-order writeback: issue 4 entries, write back tags 3,1,2,0 in successive cycles -> commit_valid stays 00 until tag 0 is done. Then 11 is shown with tags 0,1; popping both then shows tags 2,3.
- Wrap: cycle 40 issue/commit pairs through a depth-32 ring -> head and tail wrap bits toggle; count never exceeds 1; empty/full are correct at wrap.
- Flush: 10 entries at indices 28..31 and 0..5, flush_tag=30 -> tail index 31, count=3. A writeback to tag 2 the same cycle is dropped, and the next issue_tag is 31.
- Conflicts: ports 2 and 5 both write tag 7 with 0xAAAA/0x5555 -> data=0x5555. Flush and issue in the same cycle -> the issue is dropped and count is unchanged by the issue.
- Async reset mid-run: assert rst between edges with 12 entries held -> count=0 and empty=1 before the next clk edge.
